// File: rtl/icache_direct_mapped.sv
// Direct-mapped read-only instruction cache: NUM_SETS lines of 16-byte blocks, 32-bit word output.
// Latency: hits are served combinationally in the same cycle; misses stall for 1 + memory latency + 1 fill cycle.
// Backpressure: busywait stalls the fetch stage on a miss; memory stalls the fill through mem_busywait.
// Optional build macro ICACHE_STATS_EN adds saturating hit_count / miss_count outputs.
module icache_direct_mapped #(
  parameter int NUM_SETS = 8,
  parameter int INDEX_W  = $clog2(NUM_SETS),
  parameter int TAG_W    = 28 - INDEX_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         read,
  input  logic [31:0]  address,
  output logic [31:0]  instruction,
  output logic         busywait,
  output logic         mem_read,
  output logic [27:0]  mem_address,
  input  logic [127:0] mem_readdata,
  input  logic         mem_busywait
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
`endif
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_READ = 2'd1,
    UPDATE   = 2'd2
  } state_e;

  state_e             state_q;
  logic               valid_q [NUM_SETS];
  logic [TAG_W-1:0]   tag_q   [NUM_SETS];
  logic [127:0]       data_q  [NUM_SETS];
  logic               mem_read_q;
  // Latched miss block address {tag, index}; doubles as the memory address output.
  logic [27:0]        miss_addr_q;

  logic [INDEX_W-1:0] req_idx;
  logic [TAG_W-1:0]   req_tag;
  logic [6:0]         word_lsb;
  logic               hit;
  logic [INDEX_W-1:0] fill_idx;
  logic [TAG_W-1:0]   fill_tag;
  logic               unused_addr_bits;

  assign req_idx          = address[4 +: INDEX_W];
  assign req_tag          = address[4 + INDEX_W +: TAG_W];
  assign word_lsb         = {address[3:2], 5'd0};
  assign fill_idx         = miss_addr_q[INDEX_W-1:0];
  assign fill_tag         = miss_addr_q[27 -: TAG_W];
  // Byte offset within a word is irrelevant for aligned instruction fetch.
  assign unused_addr_bits = ^address[1:0];

  assign hit         = read & valid_q[req_idx] & (tag_q[req_idx] == req_tag);
  assign instruction = data_q[req_idx][word_lsb +: 32];
  // Reset gating keeps the stall low while reset is held, even with read asserted.
  assign busywait    = reset & ((state_q != IDLE) | (read & ~hit));
  assign mem_read    = mem_read_q;
  assign mem_address = miss_addr_q;

  // Miss handling FSM: latch miss address, request block, then fill the line.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      mem_read_q  <= 1'b0;
      miss_addr_q <= '0;
      for (int i = 0; i < NUM_SETS; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        data_q[i]  <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (read && !hit) begin
            miss_addr_q <= address[31:4];
            mem_read_q  <= 1'b1;
            state_q     <= MEM_READ;
          end
        end
        MEM_READ: begin
          if (!mem_busywait) begin
            mem_read_q <= 1'b0;
            state_q    <= UPDATE;
          end
        end
        UPDATE: begin
          data_q[fill_idx]  <= mem_readdata;
          tag_q[fill_idx]   <= fill_tag;
          valid_q[fill_idx] <= 1'b1;
          state_q           <= IDLE;
        end
        default: begin
          mem_read_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count_q;
  logic [31:0] miss_count_q;

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

  // Saturating counters of delivered hits and of misses entering the fill sequence.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else if (state_q == IDLE) begin
      if (hit && (hit_count_q != 32'hFFFF_FFFF)) begin
        hit_count_q <= hit_count_q + 32'd1;
      end
      if (read && !hit && (miss_count_q != 32'hFFFF_FFFF)) begin
        miss_count_q <= miss_count_q + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_icache_direct_mapped.sv
// Bench for icache_direct_mapped: directed fetches against a fixed-latency block memory model.
// Expected instructions are queued at issue and checked by a monitor whenever a word is delivered.
// Stall lengths, memory request addresses and reset behaviour are checked from the stimulus thread.
module tb_icache_direct_mapped;

  localparam int LAT  = 3;              // memory busy cycles after request seen
  localparam int MISS = LAT + 3;        // expected stalled cycles for a miss

  logic         clock;
  logic         reset;
  logic         read;
  logic [31:0]  address;
  logic [31:0]  instruction;
  logic         busywait;
  logic         mem_read;
  logic [27:0]  mem_address;
  logic [127:0] mem_readdata;
  logic         mem_busywait;
`ifdef ICACHE_STATS_EN
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;
`endif

  int           checks = 0;
  int           errors = 0;
  int           req_cnt = 0;
  logic [27:0]  last_addr = '0;
  logic [31:0]  exp_q[$];
  int           stall;

  icache_direct_mapped dut (
    .clock        (clock),
    .reset        (reset),
    .read         (read),
    .address      (address),
    .instruction  (instruction),
    .busywait     (busywait),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_readdata (mem_readdata),
    .mem_busywait (mem_busywait)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count    (hit_count),
    .miss_count   (miss_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [127:0] block(input logic [27:0] a);
    case (a)
      28'd0:   return {32'h01900213, 32'h01406193, 32'h00F00113, 32'h00A08093};
      28'd1:   return {32'h11100003, 32'h11100002, 32'h00208333, 32'h11100000};
      28'd8:   return {32'h08800003, 32'h08800002, 32'h08800001, 32'h08800000};
      default: return 128'd0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model: raise busywait on a new request, hold LAT cycles, then return the block.
  initial begin
    mem_busywait = 1'b0;
    mem_readdata = '0;
    forever begin
      @(posedge clock);
      #1;
      if (mem_read && !mem_busywait) begin
        mem_busywait = 1'b1;
        last_addr    = mem_address;
        req_cnt++;
        repeat (LAT) @(posedge clock);
        #1;
        mem_readdata = block(last_addr);
        mem_busywait = 1'b0;
      end
    end
  end

  // Monitor: every delivered word is compared against the oldest expected value.
  initial begin
    logic [31:0] exp;
    forever begin
      @(negedge clock);
      if (reset && read && !busywait) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: got %h expected none", instruction);
        end else begin
          exp = exp_q.pop_front();
          if (instruction !== exp) begin
            errors++;
            $display("FAIL instruction: got %h expected %h", instruction, exp);
          end
        end
      end
    end
  end

  // Issue one fetch; returns the number of stalled cycles before delivery.
  task automatic fetch(input logic [31:0] a, input logic [31:0] exp, output int n);
    address = a;
    read    = 1'b1;
    exp_q.push_back(exp);
    n = 0;
    @(negedge clock);
    while (busywait && n < 50) begin
      n++;
      @(negedge clock);
    end
    if (busywait) begin
      checks++;
      errors++;
      $display("FAIL fetch_timeout: got busywait=1 expected 0 for addr %h", a);
      void'(exp_q.pop_front());
    end
    @(posedge clock);
    #1;
    read = 1'b0;
  endtask

  initial begin
    // Reset with a pending read: outputs must stay quiet.
    reset   = 1'b0;
    read    = 1'b1;
    address = 32'h80;
    repeat (3) @(posedge clock);
    #1;
    check("rst_busywait", {31'd0, busywait}, 32'd0);
    check("rst_mem_read", {31'd0, mem_read}, 32'd0);
    check("rst_mem_address", {4'd0, mem_address}, 32'd0);
    check("rst_instruction", instruction, 32'd0);
    read  = 1'b0;
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Cold miss on block 0.
    fetch(32'h0, 32'h00A08093, stall);
    check("cold_stall", stall, MISS);
    check("cold_mem_addr", {4'd0, last_addr}, 32'd0);
    check("cold_req_cnt", req_cnt, 1);
    check("mem_read_after_fill", {31'd0, mem_read}, 32'd0);

    // Spatial hits within block 0.
    fetch(32'h4, 32'h00F00113, stall);
    check("hit4_stall", stall, 0);
    fetch(32'h8, 32'h01406193, stall);
    check("hit8_stall", stall, 0);
    fetch(32'hC, 32'h01900213, stall);
    check("hitC_stall", stall, 0);
    check("hits_req_cnt", req_cnt, 1);

    // Second block, then line 0 still resident.
    fetch(32'h14, 32'h00208333, stall);
    check("blk1_stall", stall, MISS);
    check("blk1_mem_addr", {4'd0, last_addr}, 32'd1);
    fetch(32'h0, 32'h00A08093, stall);
    check("reread0_stall", stall, 0);

    // Conflict eviction of line 0 by tag 1, then refetch of tag 0.
    fetch(32'h80, 32'h08800000, stall);
    check("evict_stall", stall, MISS);
    check("evict_mem_addr", {4'd0, last_addr}, 32'd8);
    fetch(32'h0, 32'h00A08093, stall);
    check("refill0_stall", stall, MISS);
    check("refill0_mem_addr", {4'd0, last_addr}, 32'd0);
    fetch(32'hC, 32'h01900213, stall);
    check("refillC_stall", stall, 0);
    check("evict_req_cnt", req_cnt, 4);

    // Reset in the middle of a miss on block 4.
    address = 32'h40;
    read    = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("midmiss_mem_read", {31'd0, mem_read}, 32'd1);
    check("midmiss_mem_addr", {4'd0, mem_address}, 32'd4);
    reset = 1'b0;
    #1;
    check("abort_mem_read", {31'd0, mem_read}, 32'd0);
    check("abort_busywait", {31'd0, busywait}, 32'd0);
    read  = 1'b0;
    #2;
    reset = 1'b1;
    repeat (10) @(posedge clock);
    #1;
    fetch(32'h0, 32'h00A08093, stall);
    check("post_rst_stall", stall, MISS);
    check("post_rst_mem_addr", {4'd0, last_addr}, 32'd0);
    fetch(32'h40, 32'h0, stall);
    check("aborted_line_stall", stall, MISS);

`ifdef ICACHE_STATS_EN
    reset = 1'b0;
    #2;
    check("stats_rst_hits", hit_count, 32'd0);
    check("stats_rst_misses", miss_count, 32'd0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    fetch(32'h0, 32'h00A08093, stall);
    fetch(32'h4, 32'h00F00113, stall);
    fetch(32'h8, 32'h01406193, stall);
    fetch(32'h14, 32'h00208333, stall);
    check("stats_misses", miss_count, 32'd2);
    check("stats_hits", hit_count, 32'd4);
`endif

    @(negedge clock);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
